// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared constants for the pipeline hazard controller
// Contents: mult/div timer state encoding, exception handler entry, MD cycle defaults.
package pipe_hazard_ctrl_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// pipe_hazard_ctrl_md_busy_timer: mult/div start qualification and busy countdown
// Ports: clk, reset (sync, active-high); md_start, md_is_div from E stage;
//        kill (exception or eret this cycle); md_go start strobe; md_busy unit occupied.
module pipe_hazard_ctrl_md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic kill,
    output logic md_go,
    output logic md_busy
);
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES - 1);
    md_state_e state_q;
    logic [3:0] cnt_q;
    assign md_go = md_start & ~kill & (state_q == IDLE);
    assign md_busy = (state_q == BUSY);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (md_go) begin
                state_q <= BUSY;
                cnt_q <= md_is_div ? DIV_LD : MULT_LD;
            end
        end else begin
            state_q <= (cnt_q == 4'd0) ? IDLE : BUSY;
            cnt_q <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush arbitration for the 5-stage pipeline
// Ports: clk, reset (sync, active-high); stall_data, md_use_id, md_start, md_is_div,
//        exc_req, eret_m in; md_go, md_busy, stall_f, clear_fd/de/em, pc_sel_exc,
//        pc_sel_eret, stall_cycles out.
// Build option: STALL_CNT_EN enables the 32-bit stall cycle counter (else tied to 0).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_data,
    input  logic        md_use_id,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        exc_req,
    input  logic        eret_m,
    output logic        md_go,
    output logic        md_busy,
    output logic        stall_f,
    output logic        clear_fd,
    output logic        clear_de,
    output logic        clear_em,
    output logic        pc_sel_exc,
    output logic        pc_sel_eret,
    output logic [31:0] stall_cycles
);
    logic redirect;
    logic md_stall;
    assign redirect = exc_req | eret_m;
    pipe_hazard_ctrl_md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .md_start(md_start),
        .md_is_div(md_is_div),
        .kill(redirect),
        .md_go(md_go),
        .md_busy(md_busy)
    );
    // the start cycle already occupies the unit, so it stalls a dependent ID op
    assign md_stall = md_use_id & (md_start | md_busy);
    // a redirect flushes the younger stages, so holding them would be pointless
    assign stall_f = ~redirect & (stall_data | md_stall);
    assign clear_de = stall_f | redirect;
    assign clear_fd = redirect;
    assign clear_em = redirect;
    assign pc_sel_exc = exc_req;
    assign pc_sel_eret = eret_m & ~exc_req;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    assign stall_cycles_d = stall_cycles_q + {31'd0, stall_f};
    always_ff @(posedge clk) begin
        stall_cycles_q <= reset ? 32'd0 : stall_cycles_d;
    end
    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_data = 1'b0, md_use_id = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
    logic exc_req = 1'b0, eret_m = 1'b0;
    logic md_go, md_busy, stall_f, clear_fd, clear_de, clear_em, pc_sel_exc, pc_sel_eret;
    logic [31:0] stall_cycles;
    typedef struct {
        logic go, busy, sf, cfd, cde, cem, pe, pr;
        logic [31:0] sc;
    } exp_t;
    exp_t q[$];
    exp_t m;
    int checks = 0;
    int errors = 0;
    int rem = 0;
    logic [31:0] sc_m = 32'd0;

    pipe_hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .stall_data(stall_data), .md_use_id(md_use_id),
        .md_start(md_start), .md_is_div(md_is_div), .exc_req(exc_req), .eret_m(eret_m),
        .md_go(md_go), .md_busy(md_busy), .stall_f(stall_f), .clear_fd(clear_fd),
        .clear_de(clear_de), .clear_em(clear_em), .pc_sel_exc(pc_sel_exc),
        .pc_sel_eret(pc_sel_eret), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // model: rem = busy cycles still to come; outputs follow the hazard rules directly
    task automatic cycle(input logic r, sd, use_id, st, dv, ex, er);
        exp_t e;
        logic stl;
        @(posedge clk);
        #1;
        reset = r; stall_data = sd; md_use_id = use_id; md_start = st;
        md_is_div = dv; exc_req = ex; eret_m = er;
        e.go = st & ~ex & ~er & (rem == 0);
        e.busy = (rem > 0);
        stl = ~ex & ~er & (sd | (use_id & (st | (rem > 0))));
        e.sf = stl;
        e.cde = stl | ex | er;
        e.cfd = ex | er;
        e.cem = ex | er;
        e.pe = ex;
        e.pr = er & ~ex;
`ifdef STALL_CNT_EN
        e.sc = sc_m;
`else
        e.sc = 32'd0;
`endif
        q.push_back(e);
        if (r) begin
            rem = 0;
            sc_m = 32'd0;
        end else begin
            if (e.go) rem = dv ? DC : MC;
            else if (rem > 0) rem = rem - 1;
            sc_m = sc_m + {31'd0, stl};
        end
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, b, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("md_go", 32'(md_go), 32'(m.go));
            chk("md_busy", 32'(md_busy), 32'(m.busy));
            chk("stall_f", 32'(stall_f), 32'(m.sf));
            chk("clear_fd", 32'(clear_fd), 32'(m.cfd));
            chk("clear_de", 32'(clear_de), 32'(m.cde));
            chk("clear_em", 32'(clear_em), 32'(m.cem));
            chk("pc_sel_exc", 32'(pc_sel_exc), 32'(m.pe));
            chk("pc_sel_eret", 32'(pc_sel_eret), 32'(m.pr));
            chk("stall_cycles", stall_cycles, m.sc);
        end
    end

    initial begin
        logic st, ex, er;
        repeat (2) @(posedge clk);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0);
        repeat (7) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 1, 0);
        repeat (9) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 1, 0);
        repeat (2) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (7) cycle(0, 1, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 0, 0);
        repeat (3) cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            st = (rem == 0) && ($urandom_range(5) == 0);
            ex = ($urandom_range(11) == 0);
            er = ($urandom_range(11) == 0);
            cycle(($urandom_range(99) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1,
                  st, $urandom_range(1) == 1, ex, er);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
